led_bin_display: RTL and testbench

Shows a 4-bit binary value on four discrete LEDs with weights 1, 2, 4 and 8. The input word is synchronized to the local clock and accepted only after it has been stable for a set number of cycles. The accepted value drives the LEDs through an optional PWM dimmer. The block sits between a 4-bit value source (switches or a decoder stage) and the board LED pins.

---
 rtl/led_bin_display_pkg.sv | 20 ++
 rtl/led_bin_stability_filter.sv | 52 +++++
 rtl/led_bin_display.sv | 63 ++++++
 tb/tb_led_bin_display.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/led_bin_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_bin_display_pkg
// Brief    : Shared types, LED bit positions and defaults for led_bin_display.
// Revision : 1.0
// ============================================================================
package led_bin_display_pkg;

    typedef logic [3:0] nibble_t;

    localparam int LED1_IDX = 0;
    localparam int LED2_IDX = 1;
    localparam int LED4_IDX = 2;
    localparam int LED8_IDX = 3;

    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_PWM_WIDTH     = 4;

endpackage
`default_nettype wire

// File: rtl/led_bin_stability_filter.sv
`default_nettype none
// ============================================================================
// Module   : led_bin_stability_filter
// Brief    : Two-flop synchronizer followed by a stable-for-N-samples filter.
// Revision : 1.0
// ============================================================================
module led_bin_stability_filter
    import led_bin_display_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] disp
);

    localparam logic [7:0] C_LAST = 8'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_disp;
    logic [7:0]       r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_cand <= '0;
            r_disp <= '0;
            r_cnt  <= 8'd0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= 8'd0;
            end else if (r_cnt == C_LAST) begin
                // Counter parks here; reloading the same value is a no-op.
                r_disp <= r_cand;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign disp = r_disp;

endmodule
`default_nettype wire

// File: rtl/led_bin_display.sv
`default_nettype none
// ============================================================================
// Module   : led_bin_display
// Brief    : Debounced 4-bit value shown on weighted LEDs with PWM dimming.
// Revision : 1.0
// ============================================================================
module led_bin_display
    import led_bin_display_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int PWM_WIDTH      = DEF_PWM_WIDTH,
    parameter int DUTY           = 16,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic    clock,
    input  logic    reset_n,
    input  nibble_t binNumber,
    output logic    led1,
    output logic    led2,
    output logic    led4,
    output logic    led8
);

    // One extra bit so DUTY == 2**PWM_WIDTH compares as always-on.
    localparam logic [PWM_WIDTH:0]   C_DUTY    = (PWM_WIDTH + 1)'(DUTY);
    localparam logic [PWM_WIDTH-1:0] C_PWM_ONE = PWM_WIDTH'(1);
    localparam nibble_t              C_POL     = LED_ACTIVE_LOW ? 4'hF : 4'h0;

    nibble_t              w_disp;
    nibble_t              w_lit;
    nibble_t              w_out;
    logic                 w_pwm_on;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;

    led_bin_stability_filter #(
        .WIDTH         (4),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (binNumber),
        .disp    (w_disp)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + C_PWM_ONE;
        end
    end

    assign w_pwm_on = ({1'b0, r_pwm_cnt} < C_DUTY);
    assign w_lit    = w_disp & {4{w_pwm_on}};
    assign w_out    = w_lit ^ C_POL;

    assign led1 = w_out[LED1_IDX];
    assign led2 = w_out[LED2_IDX];
    assign led4 = w_out[LED4_IDX];
    assign led8 = w_out[LED8_IDX];

endmodule
`default_nettype wire

// File: tb/tb_led_bin_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bin_display
// Brief    : Self-checking bench: three configurations against a run-length model.
// Revision : 1.0
// ============================================================================
module tb_led_bin_display;

    logic       clock;
    logic       reset_n;
    logic [3:0] binNumber;

    logic a1, a2, a4, a8;
    logic b1, b2, b4, b8;
    logic c1, c2, c4, c8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: queue of raw samples, run length of the value the
    // filter sees, displayed values for the 2- and 3-sample thresholds, PWM phase.
    logic [3:0] hist[$];
    logic [3:0] prev_seen;
    int         run;
    logic [3:0] md2;
    logic [3:0] md3;
    int         pc;

    led_bin_display u_dut_a (
        .clock (clock), .reset_n (reset_n), .binNumber (binNumber),
        .led1 (a1), .led2 (a2), .led4 (a4), .led8 (a8)
    );

    led_bin_display #(
        .STABLE_CYCLES (3), .PWM_WIDTH (4), .DUTY (4), .LED_ACTIVE_LOW (1'b1)
    ) u_dut_b (
        .clock (clock), .reset_n (reset_n), .binNumber (binNumber),
        .led1 (b1), .led2 (b2), .led4 (b4), .led8 (b8)
    );

    led_bin_display #(
        .STABLE_CYCLES (2), .PWM_WIDTH (3), .DUTY (0), .LED_ACTIVE_LOW (1'b0)
    ) u_dut_c (
        .clock (clock), .reset_n (reset_n), .binNumber (binNumber),
        .led1 (c1), .led2 (c2), .led4 (c4), .led8 (c8)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        prev_seen = 4'h0;
        run       = 1;
        md2       = 4'h0;
        md3       = 4'h0;
        pc        = 0;
    endtask

    // A value is shown once the filter has observed it on N+1 consecutive edges.
    task automatic model_edge();
        logic [3:0] seen;
        seen = (hist.size() >= 2) ? hist[1] : 4'h0;
        hist.push_front(binNumber);
        if (hist.size() > 3) void'(hist.pop_back());
        if (seen == prev_seen) begin
            if (run < 1000) run++;
        end else begin
            run       = 1;
            prev_seen = seen;
        end
        if (run >= 3) md2 = seen;
        if (run >= 4) md3 = seen;
        pc++;
    endtask

    task automatic check_all();
        logic [3:0] exp_b;
        exp_b = (((pc % 16) < 4) ? md3 : 4'h0) ^ 4'hF;
        check("cfgA_leds", {a8, a4, a2, a1}, md2);
        check("cfgB_leds", {b8, b4, b2, b1}, exp_b);
        check("cfgC_leds", {c8, c4, c2, c1}, 4'h0);
    endtask

    task automatic cycle(input logic [3:0] v);
        binNumber = v;
        @(posedge clock);
        if (reset_n) model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(v);
    endtask

    // Called at a falling edge: assert reset between edges, check, then release.
    task automatic mid_reset(input logic [3:0] v, input int n_in_reset);
        #3 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        for (int i = 0; i < n_in_reset; i++) cycle(v);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        binNumber = 4'h0;
        model_reset();
        #1 check_all();
        for (int i = 0; i < 4; i++) cycle(4'($urandom));
        #2 reset_n = 1'b1;
        hold(4'h0, 5);

        hold(4'b1010, 5);
        hold(4'b0111, 5);
        hold(4'b0001, 5);
        hold(4'b1111, 5);
        hold(4'b1111, 20);

        hold(4'b0011, 8);
        hold(4'b1100, 2);
        hold(4'b0011, 8);

        hold(4'b1001, 2);
        mid_reset(4'b1001, 2);
        hold(4'b1001, 8);

        for (int k = 0; k < 300; k++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                mid_reset(4'($urandom), $urandom_range(1, 3));
            end else if (kind < 5) begin
                hold(4'($urandom), $urandom_range(1, 3));
            end else begin
                hold(4'($urandom), $urandom_range(3, 8));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
